// File: rtl/led_pattern_engine.sv
// led_pattern_engine
//
// Multi-mode LED pattern generator for an N-bit LED bank. A free-running
// base counter divides the clock into base ticks, a 3-bit prescaler stretches
// the step period to 1, 2, 4 or 8 base ticks, and every step advances the
// selected pattern.
//
// Optional feature macro: LED_PATTERN_BLINK_EN
//   defined   -> mode 3 is blink (all-zeros / all-ones toggle)
//   undefined -> no blink logic; mode 3 behaves exactly like mode 0
//
// Ports
//   clk     in  1  single clock
//   rst     in  1  synchronous, active-high reset
//   mode    in  2  0 shift-left, 1 shift-right, 2 ping-pong, 3 blink
//   speed   in  2  step every 2^speed base ticks
//   pause   in  1  freeze counters and LED while high
//   LED     out N  registered LED drive
//   step_o  out 1  one-cycle pulse on every cycle a pattern step is applied
//
// Control inputs are assumed synchronous to clk.
//
// Handshake: there is none; mode/speed/pause are level controls sampled on
// every rising edge, and step_o is a single-cycle, unacknowledged pulse.

module led_pattern_engine #(
  parameter int LED_quantity   = 8,
  parameter int TIME_count     = 100000000,
  parameter int TIME_count_bit = 27
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic [1:0]              speed,
  input  logic                    pause,
  output logic [LED_quantity-1:0] LED,
  output logic                    step_o
);

  localparam int N = LED_quantity;
  localparam logic [TIME_count_bit-1:0] CNT_MAX = TIME_count_bit'(TIME_count - 1);
  localparam logic [TIME_count_bit-1:0] CNT_ONE = TIME_count_bit'(1);
  localparam logic [N-1:0] BIT_LO = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] BIT_HI = {1'b1, {(N-1){1'b0}}};

  // Ping-pong travel direction; DIR_UP moves the lit LED towards bit N-1.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [TIME_count_bit-1:0] count_q, count_d;
  logic [2:0]                pre_q,   pre_d;
  logic [1:0]                mode_q,  mode_d;
  dir_e                      dir_q,   dir_d;
  logic [N-1:0]              led_q,   led_d;
  logic                      step_q,  step_d;

  logic                      wrap;
  logic                      pre_done;
  logic                      one_hot;
  logic [N-1:0]              adv_led;
  dir_e                      adv_dir;

  // Pattern loaded on a mode change, or when the LED register holds
  // something a shift pattern cannot advance from.
  function automatic logic [N-1:0] start_pattern(input logic [1:0] m);
    logic [N-1:0] p;
    p = BIT_LO;
    case (m)
      2'd1:    p = BIT_HI;
`ifdef LED_PATTERN_BLINK_EN
      2'd3:    p = '0;
`endif
      default: p = BIT_LO;
    endcase
    return p;
  endfunction

  assign wrap = (count_q == CNT_MAX);
  // Limit is 2^speed-1; 4-bit arithmetic keeps speed=3 (limit 7) exact.
  // A pre value already above a newly lowered limit still satisfies >=.
  assign pre_done = ({1'b0, pre_q} >= ((4'd1 << speed) - 4'd1));
  assign one_hot  = (led_q != '0) && ((led_q & (led_q - BIT_LO)) == '0);

  // Next pattern value, used only on a step.
  always_comb begin
    adv_led = led_q;
    adv_dir = dir_q;
    if (!one_hot) begin
      adv_led = start_pattern(mode_q);
    end else begin
      case (mode_q)
        2'd1: adv_led = {led_q[0], led_q[N-1:1]};
        2'd2: begin
          if (dir_q == DIR_UP) begin
            if (led_q[N-1]) begin
              adv_dir = DIR_DOWN;
              adv_led = led_q >> 1;
            end else begin
              adv_led = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              adv_dir = DIR_UP;
              adv_led = led_q << 1;
            end else begin
              adv_led = led_q >> 1;
            end
          end
        end
        // Mode 0, and mode 3 when blink is not built.
        default: adv_led = {led_q[N-2:0], led_q[N-1]};
      endcase
    end
`ifdef LED_PATTERN_BLINK_EN
    // Blink ignores the one-hot rule: all-zeros is its legal start value.
    if (mode_q == 2'd3) begin
      adv_led = ~led_q;
      adv_dir = dir_q;
    end
`endif
  end

  // Priority: mode change, then pause, then normal counting.
  always_comb begin
    count_d = count_q;
    pre_d   = pre_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    led_d   = led_q;
    step_d  = 1'b0;
    if (mode != mode_q) begin
      mode_d  = mode;
      count_d = '0;
      pre_d   = '0;
      dir_d   = DIR_UP;
      led_d   = start_pattern(mode);
    end else if (!pause) begin
      if (wrap) begin
        count_d = '0;
        if (pre_done) begin
          pre_d  = '0;
          step_d = 1'b1;
          led_d  = adv_led;
          dir_d  = adv_dir;
        end else begin
          pre_d = pre_q + 3'd1;
        end
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      pre_q   <= '0;
      mode_q  <= 2'd0;
      dir_q   <= DIR_UP;
      led_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      led_q   <= led_d;
      step_q  <= step_d;
    end
  end

  assign LED    = led_q;
  assign step_o = step_q;

endmodule
